// File: rtl/arbitro_rr_4x4_pkg.sv
// Shared constants, state encoding and helpers for the 4x4 round-robin FIFO arbiter.
package arbitro_rr_4x4_pkg;

    localparam int DATA_WIDTH = 6;
    localparam int NUM_PORTS  = 4;
    localparam int DEST_MSB   = 5;
    localparam int DEST_LSB   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef logic [NUM_PORTS-1:0]  port_vec_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic port_vec_t dest_onehot(input word_t w);
        return port_vec_t'(1) << w[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/arbitro_rr_4x4_if.sv
// Bundle between the arbiter (master) and its input/output FIFO environment (slave).
interface arbitro_rr_4x4_if;
    import arbitro_rr_4x4_pkg::*;

    port_vec_t                         fifo_empty_in;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   data_in;
    port_vec_t                         pausa_in;
    port_vec_t                         pop;
    port_vec_t                         push;
    word_t                             data_out;
    logic                              valid_out;
    logic                              active_out;
    logic                              error_out;

    modport master (
        input  fifo_empty_in, data_in, pausa_in,
        output pop, push, data_out, valid_out, active_out, error_out
    );

    modport slave (
        output fifo_empty_in, data_in, pausa_in,
        input  pop, push, data_out, valid_out, active_out, error_out
    );

endinterface

// File: rtl/rr_priority_sel.sv
// Round-robin priority select: first requesting index at or above ptr, wrapping mod 4.
module rr_priority_sel
    import arbitro_rr_4x4_pkg::*;
(
    input  port_vec_t  req,
    input  logic [1:0] ptr,
    output port_vec_t  grant,
    output logic [1:0] idx
);

    logic [1:0] cand;
    logic       found;

    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_4x4.sv
// Round-robin arbiter draining four input FIFOs into four output FIFOs by destination,
// with a two-stage pop-to-push pipeline, Pausa backpressure and sticky error detection.
module arbitro_rr_4x4
    import arbitro_rr_4x4_pkg::*;
(
    input  logic             clk,
    input  logic             reset_L,
    arbitro_rr_4x4_if.master bus
);

    state_t     state, state_next;
    port_vec_t  eligible, grant, pop_next;
    logic [1:0] grant_idx, rr_ptr, pop_idx;
    logic       active_next, any_pausa;
    word_t      in_words [NUM_PORTS];
    logic       s1_valid;
    word_t      s1_data;
    logic [1:0] s1_dest;
    logic [1:0] pausa_cnt [NUM_PORTS];
    logic       overrun, empty_pop;

    assign any_pausa = |bus.pausa_in;
    // Fifo_Empty lags a pop by one cycle, so the input popped this cycle is not yet trustworthy.
    assign eligible  = ~bus.fifo_empty_in & ~bus.pop;
    assign s1_dest   = s1_data[DEST_MSB:DEST_LSB];
    // Two trailing words are legal under Pausa; a third consecutive Pausa cycle means overrun.
    assign overrun   = s1_valid && bus.pausa_in[s1_dest] && (pausa_cnt[s1_dest] >= 2'd2);
    assign empty_pop = |(bus.pop & bus.fifo_empty_in);

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_words[i] = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_priority_sel u_sel (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|eligible && !any_pausa) state_next = SERVE;
            SERVE:   if (any_pausa)               state_next = HOLD;
                     else if (!(|eligible))       state_next = IDLE;
            HOLD:    if (!any_pausa)              state_next = (|eligible) ? SERVE : IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_comb begin
        active_next = (state_next == SERVE);
        pop_next    = active_next ? grant : '0;
    end

    // NOTE: the small Pausa counter array is reset explicitly; it feeds the error decision.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            bus.pop        <= '0;
            bus.push       <= '0;
            bus.data_out   <= '0;
            bus.valid_out  <= 1'b0;
            bus.active_out <= 1'b0;
            bus.error_out  <= 1'b0;
            rr_ptr         <= '0;
            pop_idx        <= '0;
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            for (int j = 0; j < NUM_PORTS; j++) pausa_cnt[j] <= '0;
        end else begin
            bus.pop        <= pop_next;
            bus.active_out <= active_next;
            pop_idx        <= grant_idx;
            if (|pop_next) rr_ptr <= grant_idx + 2'd1;

            s1_valid <= |bus.pop;
            s1_data  <= in_words[pop_idx];

            bus.valid_out <= s1_valid;
            bus.push      <= s1_valid ? dest_onehot(s1_data) : '0;
            if (s1_valid) bus.data_out <= s1_data;

            if (overrun || empty_pop) bus.error_out <= 1'b1;

            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!bus.pausa_in[j])         pausa_cnt[j] <= '0;
                else if (pausa_cnt[j] != 2'd3) pausa_cnt[j] <= pausa_cnt[j] + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr_4x4.sv
// Randomized self-checking bench for arbitro_rr_4x4 with behavioural FIFOs and a rule-level model.
module tb_arbitro_rr_4x4;
    import arbitro_rr_4x4_pkg::*;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    arbitro_rr_4x4_if bus ();

    arbitro_rr_4x4 dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural input FIFOs and environment controls
    logic [5:0] q [4][$];
    logic [3:0] pausa_v     = '0;
    logic [3:0] empty_force = '0;
    logic       rst_v       = 1'b0;
    logic [3:0] live_pop    = '0;
    logic [3:0] done_pop    = '0;
    int         pop_count [4];

    // Reference model: pop rule is "no Pausa and something eligible -> next eligible from ptr"
    logic [3:0] m_pop;
    int         m_ptr;
    logic       m_s1_valid;
    logic [5:0] m_s1_word;
    int         m_pcnt [4];
    logic       m_err;
    logic [3:0] e_pop, e_push;
    logic [5:0] e_data;
    logic       e_valid, e_active, e_err;

    task automatic model_reset();
        m_pop = '0; m_ptr = 0; m_s1_valid = 1'b0; m_s1_word = '0; m_err = 1'b0;
        for (int j = 0; j < 4; j++) m_pcnt[j] = 0;
        e_pop = '0; e_push = '0; e_data = '0; e_valid = 1'b0; e_active = 1'b0; e_err = 1'b0;
    endtask

    task automatic cycle();
        logic [3:0] empt, elig, new_pop;
        logic [5:0] slice [4];
        int         idx, dest;
        for (int i = 0; i < 4; i++) if (done_pop[i] && q[i].size() > 0) void'(q[i].pop_front());
        done_pop = live_pop;
        for (int i = 0; i < 4; i++) begin
            empt[i]  = (q[i].size() == 0) || empty_force[i];
            slice[i] = (q[i].size() > 0) ? q[i][0] : 6'd0;
        end
        bus.fifo_empty_in = empt;
        bus.data_in       = {slice[3], slice[2], slice[1], slice[0]};
        bus.pausa_in      = pausa_v;
        reset_L           = rst_v;

        if (!rst_v) begin
            model_reset();
        end else begin
            elig    = ~empt & ~m_pop;
            new_pop = '0;
            if (pausa_v == 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (new_pop == 4'b0000 && elig[idx]) begin
                        new_pop[idx] = 1'b1;
                        m_ptr        = (idx + 1) % 4;
                    end
                end
            end
            if (m_s1_valid) begin
                dest   = int'(m_s1_word[5:4]);
                e_push = 4'(1 << dest);
                e_data = m_s1_word;
                if (pausa_v[dest] && m_pcnt[dest] >= 2) m_err = 1'b1;
            end else begin
                e_push = '0;
            end
            e_valid = m_s1_valid;
            if ((m_pop & empt) != 4'b0000) m_err = 1'b1;
            m_s1_valid = (m_pop != 4'b0000);
            for (int i = 0; i < 4; i++) if (m_pop[i]) m_s1_word = slice[i];
            for (int j = 0; j < 4; j++) m_pcnt[j] = pausa_v[j] ? ((m_pcnt[j] < 3) ? m_pcnt[j] + 1 : 3) : 0;
            m_pop    = new_pop;
            e_pop    = new_pop;
            e_active = (new_pop != 4'b0000);
            e_err    = m_err;
        end

        @(posedge clk);
        @(negedge clk);

        checks++; if (bus.pop !== e_pop) begin errors++; $display("FAIL pop t=%0t: got %b expected %b", $time, bus.pop, e_pop); end
        checks++; if (bus.push !== e_push) begin errors++; $display("FAIL push t=%0t: got %b expected %b", $time, bus.push, e_push); end
        checks++; if (bus.valid_out !== e_valid) begin errors++; $display("FAIL valid_out t=%0t: got %b expected %b", $time, bus.valid_out, e_valid); end
        checks++; if (bus.data_out !== e_data) begin errors++; $display("FAIL data_out t=%0t: got %b expected %b", $time, bus.data_out, e_data); end
        checks++; if (bus.active_out !== e_active) begin errors++; $display("FAIL active_out t=%0t: got %b expected %b", $time, bus.active_out, e_active); end
        checks++; if (bus.error_out !== e_err) begin errors++; $display("FAIL error_out t=%0t: got %b expected %b", $time, bus.error_out, e_err); end

        live_pop = bus.pop;
        for (int i = 0; i < 4; i++) if (live_pop[i]) pop_count[i]++;
    endtask

    // Two reset cycles with empty FIFOs; the next cycle() call is the release edge.
    task automatic reset_env();
        for (int i = 0; i < 4; i++) begin q[i].delete(); pop_count[i] = 0; end
        pausa_v = '0; empty_force = '0; rst_v = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 4; i++) pop_count[i] = 0;
        rst_v = 1'b1;
    endtask

    task automatic fill_all(input int n);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < n; k++) q[i].push_back(6'($urandom_range(0, 63)));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        fill_all(4);
        rst_v = 1'b0;
        repeat (3) cycle();
        checks++;
        if (bus.pop !== 4'b0000 || bus.active_out !== 1'b0 || bus.error_out !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got pop=%b active=%b err=%b expected all zero", bus.pop, bus.active_out, bus.error_out);
        end
        rst_v = 1'b1;
        cycle();
        checks++;
        if (bus.pop !== 4'b0001) begin errors++; $display("FAIL reset_first_pop: got %b expected 0001", bus.pop); end
    endtask

    task automatic test_single_input();
        logic [3:0] gp [$];
        logic [5:0] gd [$];
        logic       prev2;
        reset_env();
        q[2].push_back(6'b010011);
        q[2].push_back(6'b110001);
        prev2 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (bus.valid_out) begin gp.push_back(bus.push); gd.push_back(bus.data_out); end
            checks++;
            if (bus.pop[2] && prev2) begin errors++; $display("FAIL single_back_to_back: got pop[2] twice in a row expected gap"); end
            prev2 = bus.pop[2];
        end
        checks++;
        if (pop_count[2] != 2) begin errors++; $display("FAIL single_pop_count: got %0d expected 2", pop_count[2]); end
        checks++;
        if (gp.size() != 2) begin
            errors++; $display("FAIL single_push_count: got %0d expected 2", gp.size());
        end else if (gp[0] !== 4'b0010 || gd[0] !== 6'b010011 || gp[1] !== 4'b1000 || gd[1] !== 6'b110001) begin
            errors++; $display("FAIL single_push_data: got %b/%b %b/%b expected 0010/010011 1000/110001", gp[0], gd[0], gp[1], gd[1]);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] want;
        reset_env();
        fill_all(6);
        for (int c = 0; c < 16; c++) begin
            cycle();
            want = 4'(1 << (c % 4));
            checks++;
            if (bus.pop !== want) begin errors++; $display("FAIL fairness_c%0d: got %b expected %b", c, bus.pop, want); end
        end
    endtask

    task automatic test_backpressure();
        int trail;
        reset_env();
        fill_all(8);
        repeat (5) cycle();
        pausa_v = 4'b0001;
        cycle();
        checks++;
        if (bus.pop !== 4'b0000 || bus.active_out !== 1'b0) begin
            errors++; $display("FAIL pausa_stop: got pop=%b active=%b expected 0000/0", bus.pop, bus.active_out);
        end
        trail = bus.valid_out ? 1 : 0;
        repeat (3) begin cycle(); if (bus.valid_out) trail++; end
        checks++;
        if (trail != 2) begin errors++; $display("FAIL pausa_trailing: got %0d pushes expected 2", trail); end
        pausa_v = 4'b0000;
        cycle();
        checks++;
        if (bus.pop !== 4'b0010) begin errors++; $display("FAIL pausa_resume: got %b expected 0010", bus.pop); end
    endtask

    task automatic test_overrun();
        reset_env();
        pausa_v = 4'b1000;
        repeat (4) cycle();
        force dut.s1_valid = 1'b1;
        force dut.s1_data  = 6'b110000;
        @(posedge clk);
        @(negedge clk);
        release dut.s1_valid;
        release dut.s1_data;
        checks++;
        if (bus.error_out !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", bus.error_out); end
        bus.pausa_in = 4'b0000;
        pausa_v      = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.error_out !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", bus.error_out); end
        rst_v = 1'b0;
        cycle();
        checks++;
        if (bus.error_out !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", bus.error_out); end
        rst_v = 1'b1;
    endtask

    task automatic test_empty_error();
        reset_env();
        for (int k = 0; k < 3; k++) q[1].push_back(6'($urandom_range(0, 63)));
        cycle();
        empty_force = 4'b0010;
        cycle();
        checks++;
        if (bus.error_out !== 1'b1) begin errors++; $display("FAIL empty_pop_error: got %b expected 1", bus.error_out); end
        empty_force = 4'b0000;
        repeat (3) cycle();
    endtask

    task automatic test_empty_lag();
        reset_env();
        q[3].push_back(6'b011010);
        repeat (6) cycle();
        checks++;
        if (pop_count[3] != 1) begin errors++; $display("FAIL lag_pop_count: got %0d expected 1", pop_count[3]); end
        checks++;
        if (bus.error_out !== 1'b0) begin errors++; $display("FAIL lag_error: got %b expected 0", bus.error_out); end
    endtask

    task automatic test_random();
        int w;
        reset_env();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
                if (q[i].size() < 8 && $urandom_range(0, 2) == 0) q[i].push_back(6'($urandom_range(0, 63)));
            pausa_v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            w       = $urandom_range(0, 99);
            rst_v   = (w != 0);
            cycle();
        end
        rst_v = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 4; i++) pop_count[i] = 0;
        test_reset();
        test_single_input();
        test_fairness();
        test_backpressure();
        test_overrun();
        test_empty_error();
        test_empty_lag();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
